// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control decoder with multi-cycle MUL sequencing.
// Optional build macro ALU_CTRL_SHIFT_EN adds LSL/LSR decode.
module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       funct,
    input  logic [1:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal,
    output logic              busy
);
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [10:0] F_ADD  = 11'b10001011000;
    localparam logic [10:0] F_SUB  = 11'b11001011000;
    localparam logic [10:0] F_AND  = 11'b10001010000;
    localparam logic [10:0] F_ORR  = 11'b10101010000;
    localparam logic [10:0] F_MUL  = 11'b10011011000;
    localparam logic [9:0]  F_ADDI = 10'b1001000100;
    localparam logic [9:0]  F_SUBI = 10'b1101000100;
`ifdef ALU_CTRL_SHIFT_EN
    localparam logic [10:0] F_LSL  = 11'b11010011011;
    localparam logic [10:0] F_LSR  = 11'b11010011010;
`endif

    typedef enum logic [1:0] {IDLE, MULTI, VALID} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    code_r, dec_code;
    logic          ill_r, dec_ill, dec_mul, accept;

    assign in_ready   = (state == IDLE) || (state == VALID && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = state == VALID;
    assign busy       = state == MULTI;
    assign alucontrol = CTRL_W'(code_r);
    assign illegal    = ill_r;

    // Decode aluop/funct into the 4-bit control code; first match wins.
    always_comb begin
        dec_code = 4'b0000;
        dec_ill  = 1'b0;
        dec_mul  = 1'b0;
        if (aluop == 2'b00) dec_code = 4'b0010;
        else if (aluop == 2'b01) dec_code = 4'b0111;
        else if (aluop == 2'b10 && funct == F_ADD) dec_code = 4'b0010;
        else if (aluop == 2'b10 && funct == F_SUB) dec_code = 4'b0110;
        else if (aluop == 2'b10 && funct == F_AND) dec_code = 4'b0000;
        else if (aluop == 2'b10 && funct == F_ORR) dec_code = 4'b0001;
        else if (aluop == 2'b10 && funct == F_MUL) begin
            dec_code = 4'b1100;
            dec_mul  = 1'b1;
        end
        else if (aluop == 2'b10 && funct[10:1] == F_ADDI) dec_code = 4'b0010;
        else if (aluop == 2'b10 && funct[10:1] == F_SUBI) dec_code = 4'b0110;
`ifdef ALU_CTRL_SHIFT_EN
        else if (aluop == 2'b10 && funct == F_LSL) dec_code = 4'b1000;
        else if (aluop == 2'b10 && funct == F_LSR) dec_code = 4'b1001;
`endif
        else dec_ill = 1'b1;
    end

    // Next state: accept has priority; MULTI counts down and leaves on cnt==1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = (dec_mul && MUL_LAT > 1) ? MULTI : VALID;
            cnt_nx   = dec_mul ? CW'(MUL_LAT - 1) : cnt;
        end else if (state == MULTI) begin
            state_nx = (cnt == CW'(1)) ? VALID : MULTI;
            cnt_nx   = (cnt == CW'(1)) ? cnt : cnt - CW'(1);
        end else if (state == VALID && out_ready) begin
            state_nx = IDLE;
        end
    end

    // State, counter and result registers; results load only on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            code_r <= 4'b0000;
            ill_r  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                code_r <= dec_code;
                ill_r  <= dec_ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed bench with a transaction-level reference model for alu_ctrl_seq.
module tb_alu_ctrl_seq;
    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 4;
    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDF = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] MUL  = 11'b10011011000;
    localparam logic [10:0] ADDI = 11'b10010001000;
    localparam logic [10:0] SUBI = 11'b11010001001;
    localparam logic [10:0] LSL  = 11'b11010011011;
    localparam logic [10:0] LSR  = 11'b11010011010;

    logic              clk, reset, in_valid, in_ready, out_valid, out_ready, illegal, busy;
    logic [10:0]       funct;
    logic [1:0]        aluop;
    logic [CTRL_W-1:0] alucontrol;

    int checks = 0;
    int errors = 0;

    alu_ctrl_seq #(.CTRL_W(CTRL_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .aluop(aluop), .out_valid(out_valid), .out_ready(out_ready),
        .alucontrol(alucontrol), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode table: returns {illegal, code}.
    function automatic logic [4:0] ref_dec(input logic [1:0] a, input logic [10:0] f);
        if (a == 2'b00) return 5'b0_0010;
        if (a == 2'b01) return 5'b0_0111;
        if (a == 2'b11) return 5'b1_0000;
        case (f)
            ADD:  return 5'b0_0010;
            SUB:  return 5'b0_0110;
            ANDF: return 5'b0_0000;
            ORR:  return 5'b0_0001;
            MUL:  return 5'b0_1100;
`ifdef ALU_CTRL_SHIFT_EN
            LSL:  return 5'b0_1000;
            LSR:  return 5'b0_1001;
`endif
            default: ;
        endcase
        if (f[10:1] == 10'b1001000100) return 5'b0_0010;
        if (f[10:1] == 10'b1101000100) return 5'b0_0110;
        return 5'b1_0000;
    endfunction

    // Model: one result slot that becomes visible `latency` cycles after accept.
    int         cyc = 0;
    bit         m_have = 0;
    int         m_rdy = 0;
    logic [3:0] m_code = 0;
    logic       m_ill = 0;

    function automatic bit m_ov();
        return m_have && cyc >= m_rdy;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [4:0] r;
        bit ir;
        if (!reset) begin
            m_have = 0;
            m_code = 0;
            m_ill  = 0;
        end else begin
            ir = !m_have || (m_ov() && out_ready);
            if (m_ov() && out_ready) m_have = 0;
            if (in_valid && ir) begin
                r      = ref_dec(aluop, funct);
                m_code = r[3:0];
                m_ill  = r[4];
                m_have = 1;
                m_rdy  = cyc + ((aluop == 2'b10 && funct == MUL) ? MUL_LAT : 1);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("out_valid", out_valid, m_ov());
            check("busy", busy, m_have && cyc < m_rdy);
            check("in_ready", in_ready, !m_have || (m_ov() && out_ready));
            if (m_ov()) begin
                check("alucontrol", alucontrol, m_code);
                check("illegal", illegal, m_ill);
            end
        end
    end

    task automatic drive(input logic iv, input logic [1:0] a, input logic [10:0] f, input logic r);
        @(posedge clk);
        #1;
        in_valid = iv; aluop = a; funct = f; out_ready = r;
    endtask

    task automatic single(input string name, input logic [1:0] a, input logic [10:0] f,
                          input logic [3:0] ec, input logic ei);
        drive(1'b1, a, f, 1'b1);
        drive(1'b0, 2'b00, 11'd0, 1'b1);
        #5;
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_code"}, alucontrol, ec);
        check({name, "_ill"}, illegal, ei);
    endtask

    typedef struct {logic iv; logic [1:0] a; logic [10:0] f; logic r;} vec_t;
    vec_t stream [14] = '{
        '{1'b1, 2'b10, ANDF, 1'b1}, '{1'b1, 2'b01, 11'h7ff, 1'b1}, '{1'b1, 2'b10, MUL, 1'b1},
        '{1'b1, 2'b10, ORR, 1'b1},  '{1'b1, 2'b10, ORR, 1'b1},     '{1'b1, 2'b10, ORR, 1'b0},
        '{1'b1, 2'b10, SUBI, 1'b0}, '{1'b1, 2'b10, SUBI, 1'b1},    '{1'b1, 2'b00, 11'h123, 1'b0},
        '{1'b1, 2'b10, MUL, 1'b1},  '{1'b0, 2'b11, 11'd0, 1'b0},   '{1'b1, 2'b10, 11'h555, 1'b1},
        '{1'b0, 2'b00, 11'd0, 1'b0}, '{1'b0, 2'b00, 11'd0, 1'b1}
    };

    initial begin
        reset = 1'b0; in_valid = 1'b0; aluop = 2'b00; funct = 11'd0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alucontrol", alucontrol, 4'b0000);
        check("rst_illegal", illegal, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_in_ready", in_ready, 1'b1);

        single("add", 2'b10, ADD, 4'b0010, 1'b0);

        drive(1'b1, 2'b10, MUL, 1'b1);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            drive(1'b0, 2'b00, 11'd0, 1'b1);
            #5;
            check("mul_busy", busy, 1'b1);
            check("mul_in_ready", in_ready, 1'b0);
            check("mul_early_valid", out_valid, 1'b0);
        end
        drive(1'b0, 2'b00, 11'd0, 1'b1);
        #5;
        check("mul_valid", out_valid, 1'b1);
        check("mul_code", alucontrol, 4'b1100);
        check("mul_busy_end", busy, 1'b0);

        drive(1'b1, 2'b10, SUB, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, ORR, 1'b0);
            #5;
            check("bp_code", alucontrol, 4'b0110);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_valid", out_valid, 1'b1);
        end
        drive(1'b1, 2'b10, ORR, 1'b1);
        #5 check("bp_release_ready", in_ready, 1'b1);
        drive(1'b0, 2'b00, 11'd0, 1'b1);
        #5;
        check("orr_valid", out_valid, 1'b1);
        check("orr_code", alucontrol, 4'b0001);

        drive(1'b1, 2'b10, MUL, 1'b1);
        drive(1'b0, 2'b00, 11'd0, 1'b1);
        drive(1'b0, 2'b00, 11'd0, 1'b1);
        #1 check("pre_rst_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_alucontrol", alucontrol, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);

`ifdef ALU_CTRL_SHIFT_EN
        single("lsl", 2'b10, LSL, 4'b1000, 1'b0);
        single("lsr", 2'b10, LSR, 4'b1001, 1'b0);
`else
        single("lsl", 2'b10, LSL, 4'b0000, 1'b1);
        single("lsr", 2'b10, LSR, 4'b0000, 1'b1);
`endif
        single("aluop11", 2'b11, ADD, 4'b0000, 1'b1);
        single("addi0", 2'b10, ADDI, 4'b0010, 1'b0);
        single("addi1", 2'b10, ADDI | 11'd1, 4'b0010, 1'b0);
        single("subi", 2'b10, SUBI, 4'b0110, 1'b0);
        single("cbz", 2'b01, MUL, 4'b0111, 1'b0);
        single("ldur", 2'b00, 11'h7ff, 4'b0010, 1'b0);
        single("and", 2'b10, ANDF, 4'b0000, 1'b0);
        single("unknown", 2'b10, 11'h001, 4'b0000, 1'b1);

        foreach (stream[i]) drive(stream[i].iv, stream[i].a, stream[i].f, stream[i].r);
        repeat (MUL_LAT + 3) drive(1'b0, 2'b00, 11'd0, 1'b1);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
